// File: rtl/img_pkg.sv
// Shared definitions for the image UART loader: frame geometry, pixel type
// and loader FSM states.
package img_pkg;

    localparam int H_RES        = 320;
    localparam int V_RES        = 240;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int ADDR_W       = 17;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } loader_state_t;

endpackage

// File: rtl/img_uart_loader_packer.sv
// rgb_byte_packer: gathers R, G, B bytes into one pixel. The byte index and
// the R/G holding registers live here. pixel_valid is combinational and
// fires in the cycle the B byte is accepted.
module rgb_byte_packer
    import img_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       byte_en,
    input  logic [7:0] byte_in,
    output logic       pixel_valid,
    output rgb24_t     pixel
);

    logic [1:0] idx;
    logic [7:0] r_q;
    logic [7:0] g_q;

    // Byte index walks R -> G -> B; clr drops any partial pixel
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            idx <= 2'd0;
            r_q <= 8'd0;
            g_q <= 8'd0;
        end else if (byte_en) begin
            case (idx)
                2'd0: begin
                    r_q <= byte_in;
                    idx <= 2'd1;
                end
                2'd1: begin
                    g_q <= byte_in;
                    idx <= 2'd2;
                end
                default: idx <= 2'd0;
            endcase
        end
    end

    assign pixel_valid = byte_en && (idx == 2'd2);
    assign pixel       = '{r: r_q, g: g_q, b: byte_in};

endmodule

// File: rtl/img_uart_loader.sv
// img_uart_loader: turns a UART RGB888 byte stream into sequential 24-bit
// frame-buffer writes. Optional idle-timeout resync is enabled by defining
// IMG_UART_LOADER_TIMEOUT_EN.
module img_uart_loader
    import img_pkg::*;
#(
    parameter int H_RES          = img_pkg::H_RES,
    parameter int V_RES          = img_pkg::V_RES,
    parameter int ADDR_W         = img_pkg::ADDR_W,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int NPIX = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic              accept;
    logic              pix_valid;
    rgb24_t            pixel;
    logic [ADDR_W-1:0] pix_cnt;
    logic              last_pix;
    logic              timeout;

    // A byte counts only while the loader is enabled
    assign accept   = rx_ready && load_en;
    assign last_pix = (pix_cnt == LAST_PIX);

    rgb_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (timeout),
        .byte_en     (accept),
        .byte_in     (rx_data),
        .pixel_valid (pix_valid),
        .pixel       (pixel)
    );

`ifdef IMG_UART_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;

    // Counts idle cycles mid-frame; any accepted byte restarts the gap
    always_ff @(posedge clk) begin
        if (!rst_n || !busy || accept || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = busy && !accept && (idle_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: first byte opens a frame, last pixel or timeout closes it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RECV;
            RECV: begin
                if (pix_valid && last_pix)
                    state_nxt = IDLE;
                else if (timeout)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == RECV);
    end

    // Write port and pixel counter; address/data hold between writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 24'd0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            wr_en      <= pix_valid;
            frame_done <= pix_valid && last_pix;
            if (pix_valid) begin
                wr_addr <= pix_cnt;
                wr_data <= pixel;
                pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            end else if (timeout) begin
                pix_cnt <= '0;
            end
        end
    end

endmodule
